// File: rtl/icache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_fill_fsm_pkg
// Description : Shared constants for the instruction-cache block-fill
//               controller: FSM state encoding, block geometry and the
//               block-base address mask.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_fill_fsm_pkg;

    // Default block geometry: 8 words of 16 bits = 16-byte block
    localparam int c_words       = 8;
    localparam int c_block_bytes = 2 * c_words;
    localparam int c_offset_w    = $clog2(c_words);

    // Clears the byte-in-block bits of a 16-bit address
    localparam logic [15:0] c_block_mask = ~16'(c_block_bytes - 1);

    // Controller states
    localparam logic [0:0] c_state_idle = 1'b0;
    localparam logic [0:0] c_state_fill = 1'b1;

endpackage : icache_fill_fsm_pkg
`default_nettype wire

// File: rtl/icache_fill_fsm_fill_counter.sv
`default_nettype none
// ============================================================================
// Module      : fill_counter
// Description : Up-counter with synchronous clear and count enable. Clear has
//               priority over enable. Used for both the request and the
//               receive word counts of a block fill.
// Revision    : 1.0 - initial release
// ============================================================================
module fill_counter
    import icache_fill_fsm_pkg::*;
#(
    parameter int WIDTH = c_offset_w + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins over enable; async reset to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : fill_counter
`default_nettype wire

// File: rtl/icache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : icache_fill_fsm
// Description : Instruction-cache miss controller. On a miss it issues one
//               word read per cycle for the whole aligned block, streams each
//               returned word into the data array at its slot, and writes the
//               tag together with the last word. Fetch stalls on fsm_busy.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fill_fsm
    import icache_fill_fsm_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = c_words
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    input  logic                     memory_data_valid,
    input  logic [DATA_W-1:0]        memory_data,
    output logic                     fsm_busy,
    output logic                     mem_read,
    output logic [ADDR_W-1:0]        memory_address,
    output logic                     write_data_array,
    output logic [$clog2(WORDS)-1:0] word_offset,
    output logic                     write_tag_array,
    output logic                     fill_done
);

    localparam int c_off_w = $clog2(WORDS);
    localparam int c_cnt_w = c_off_w + 1;

    // Block-base mask; falls back to a locally derived mask for
    // non-default geometries
    localparam logic [ADDR_W-1:0] c_base_mask =
        (ADDR_W == 16 && WORDS == c_words) ? ADDR_W'(c_block_mask)
                                           : ~ADDR_W'(2 * WORDS - 1);

    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_addr_hold;
    logic [c_cnt_w-1:0] w_req_cnt;
    logic [c_cnt_w-1:0] w_rcv_cnt;
    logic               w_in_fill;
    logic               w_accept;
    logic               w_req_issue;
    logic               w_rcv_word;
    logic               w_last_word;
    logic [ADDR_W-1:0]  w_req_addr;
    logic               w_unused_data;

    // The data word goes straight to the data array; it is not used here
    assign w_unused_data = ^memory_data;

    assign w_in_fill   = (r_state == c_state_fill);
    assign w_accept    = (r_state == c_state_idle) & miss_detected;
    // Requests stop once the counter MSB sets (all WORDS issued)
    assign w_req_issue = w_in_fill & ~w_req_cnt[c_cnt_w-1];
    assign w_rcv_word  = w_in_fill & memory_data_valid;
    assign w_last_word = w_rcv_word & (w_rcv_cnt == c_cnt_w'(WORDS - 1));
    // Word address inside the block; base is aligned so there is no carry
    // out of the block, and the sum wraps modulo 2^ADDR_W
    assign w_req_addr  = r_base + ADDR_W'({w_req_cnt[c_off_w-1:0], 1'b0});

    fill_counter #(
        .WIDTH (c_cnt_w)
    ) u_req_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_accept),
        .enable (w_req_issue),
        .count  (w_req_cnt)
    );

    fill_counter #(
        .WIDTH (c_cnt_w)
    ) u_rcv_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_accept),
        .enable (w_rcv_word),
        .count  (w_rcv_cnt)
    );

    // FSM: latch the block base on an accepted miss, leave on the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_state_idle;
            r_base  <= '0;
        end else begin
            case (r_state)
                c_state_idle: begin
                    if (miss_detected) begin
                        r_base  <= miss_address & c_base_mask;
                        r_state <= c_state_fill;
                    end
                end
                c_state_fill: begin
                    if (w_last_word) begin
                        r_state <= c_state_idle;
                    end
                end
                default: r_state <= c_state_idle;
            endcase
        end
    end

    // Remember the last issued address so memory_address holds it afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_hold <= '0;
        end else if (w_req_issue) begin
            r_addr_hold <= w_req_addr;
        end
    end

    assign fsm_busy         = w_in_fill;
    assign mem_read         = w_req_issue;
    assign memory_address   = w_req_issue ? w_req_addr : r_addr_hold;
    assign write_data_array = w_rcv_word;
    assign word_offset      = w_rcv_cnt[c_off_w-1:0];
    assign write_tag_array  = w_last_word;
    assign fill_done        = w_last_word;

endmodule : icache_fill_fsm
`default_nettype wire

// File: tb/tb_icache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fill_fsm
// Description : Self-checking bench for icache_fill_fsm: a cycle table for
//               the basic fill, hand sequences for reset/stall/back-to-back
//               cases, and randomized fills against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fill_fsm;

    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_offset;
    logic        write_tag_array;
    logic        fill_done;
    logic [23:0] w_out;

    icache_fill_fsm #(
        .ADDR_W (16),
        .DATA_W (16),
        .WORDS  (WORDS)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_offset       (word_offset),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    always #5 clk = ~clk;

    assign w_out = {fsm_busy, mem_read, memory_address, write_data_array,
                    word_offset, write_tag_array, fill_done};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Transaction-level reference: outstanding expected request addresses,
    // number of words written in the current fill, busy flag
    bit          m_busy = 1'b0;
    logic [15:0] exp_q[$];
    int          m_nwr  = 0;
    int          n_done = 0;
    int          mq[$];              // memory model: ready cycle per request
    int          dut_done_cycs[$];
    int          dut_start_cycs[$];
    logic        prev_rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [23:0] pk(input logic b, input logic r, input logic [15:0] a,
                                       input logic w, input logic [2:0] o,
                                       input logic t, input logic d);
        return {b, r, a, w, o, t, d};
    endfunction

    // Compare DUT outputs against the reference for the current cycle, then
    // advance the reference using this cycle's inputs
    task automatic model_check();
        logic exp_rd, exp_wr, exp_last;
        logic [15:0] base;
        chk("busy", fsm_busy, m_busy);
        exp_rd = m_busy && (exp_q.size() > 0);
        chk("mem_read", mem_read, exp_rd);
        if (exp_rd) begin
            chk("mem_addr", memory_address, exp_q[0]);
            void'(exp_q.pop_front());
        end
        exp_wr = m_busy && memory_data_valid;
        chk("write_data", write_data_array, exp_wr);
        if (exp_wr) chk("word_offset", word_offset, m_nwr);
        exp_last = exp_wr && (m_nwr == WORDS - 1);
        chk("write_tag", write_tag_array, exp_last);
        chk("fill_done", fill_done, exp_last);
        if (mem_read && !prev_rd) dut_start_cycs.push_back(cyc);
        if (fill_done) dut_done_cycs.push_back(cyc);
        prev_rd = mem_read;
        if (exp_wr) m_nwr++;
        if (exp_last) begin
            m_busy = 1'b0;
            n_done++;
        end else if (!m_busy && miss_detected) begin
            m_busy = 1'b1;
            base   = miss_address & ~16'(2 * WORDS - 1);
            exp_q.delete();
            for (int i = 0; i < WORDS; i++) exp_q.push_back(16'(base + 16'(2 * i)));
            m_nwr  = 0;
        end
    endtask

    task automatic tick(input logic miss, input logic [15:0] a, input logic v);
        @(posedge clk);
        cyc++;
        #1;
        miss_detected     = miss;
        miss_address      = a;
        memory_data_valid = v;
        memory_data       = 16'($urandom);
        @(negedge clk);
        model_check();
    endtask

    // Drive a memory of fixed latency with random gaps until `target` more
    // fills have completed
    task automatic run(input int target, input int lat, input int gap_pct,
                       input int miss_pct, input logic [15:0] fa, input bit fixed);
        int goal;
        int budget;
        logic v, m;
        logic [15:0] a;
        goal   = n_done + target;
        budget = 0;
        while (n_done < goal && budget < 400) begin
            v = 1'b0;
            if (mq.size() > 0 && mq[0] <= cyc + 1 && $urandom_range(0, 99) >= gap_pct) begin
                v = 1'b1;
                void'(mq.pop_front());
            end
            m = ($urandom_range(0, 99) < miss_pct);
            a = fixed ? fa : 16'($urandom);
            tick(m, a, v);
            if (mem_read) mq.push_back(cyc + lat);
            budget++;
        end
        if (n_done < goal) begin
            n_chk++;
            $display("FAIL run_timeout: fills done %0d, required %0d", n_done, goal);
        end
    endtask

    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[15];
    int   pat[12] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};

    initial begin
        // Basic fill with a 4-cycle memory: row k is cycle N+k
        for (int k = 0; k < 15; k++) begin
            logic        b, r, w, d;
            logic [15:0] a;
            logic [2:0]  o;
            b = (k >= 1 && k <= 12);
            r = (k >= 1 && k <= 8);
            a = (k == 0) ? 16'h0000 : (k <= 8) ? 16'(16'h1230 + 2 * (k - 1)) : 16'h123E;
            w = (k >= 5 && k <= 12);
            o = w ? 3'(k - 5) : 3'd0;
            d = (k == 12);
            tbl[k].miss  = (k == 0);
            tbl[k].addr  = 16'h1236;
            tbl[k].valid = (k >= 5);
            tbl[k].exp   = pk(b, r, a, w, o, d, d);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", w_out, 24'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            tick(tbl[k].miss, tbl[k].addr, tbl[k].valid);
            chk($sformatf("vec%0d", k), w_out, tbl[k].exp);
        end

        // Wrap boundary: base 0xFFF0, requests up to 0xFFFE
        tick(1'b1, 16'hFFF9, 1'b0);
        run(1, 3, 0, 0, 16'h0, 1'b0);
        chk("wrap_last_addr", memory_address, 16'hFFFE);

        // Stalling memory: fill_done lands on the 8th valid
        tick(1'b1, 16'h5000, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 16'h0, pat[i] != 0);
        chk("stall_done_on_8th", fill_done, 1'b1);

        // Spurious misses mid-fill, spurious valids while idle
        tick(1'b1, 16'h3456, 1'b0);
        run(1, 3, 20, 30, 16'h0, 1'b0);
        repeat (3) tick(1'b0, 16'h0, 1'b1);

        // Reset after the third data word
        tick(1'b1, 16'h2004, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        repeat (3) tick(1'b0, 16'h0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", w_out, 24'h0);
        repeat (2) @(negedge clk);
        chk("rst_held_outputs", w_out, 24'h0);
        m_busy = 1'b0;
        exp_q.delete();
        mq.delete();
        m_nwr = 0;
        prev_rd = 1'b0;
        memory_data_valid = 1'b0;
        rst_n = 1'b1;
        tick(1'b1, 16'h0040, 1'b0);
        run(1, 4, 0, 0, 16'h0, 1'b0);
        chk("post_rst_last_addr", memory_address, 16'h004E);

        // Back-to-back: miss held high across completion
        tick(1'b1, 16'h7777, 1'b0);
        run(2, 4, 0, 100, 16'h9ABC, 1'b1);
        chk("b2b_gap", dut_start_cycs[dut_start_cycs.size() - 1]
                       - dut_done_cycs[dut_done_cycs.size() - 2], 2);
        chk("b2b_new_base_last", memory_address, 16'h9ABE);
        tick(1'b0, 16'h0, 1'b0);

        // Randomized fills
        for (int f = 0; f < 20; f++) begin
            tick(1'b1, 16'($urandom), 1'b0);
            run(1, $urandom_range(1, 6), $urandom_range(0, 50), 20, 16'h0, 1'b0);
            repeat ($urandom_range(0, 3)) tick(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_icache_fill_fsm
`default_nettype wire
